// File: rtl/binarization_threshold_ctrl_pkg.sv
// rtl/binarization_threshold_ctrl_pkg.sv - shared types and default constants for the threshold controller
package binarization_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DIV   = 2'd2,
    UPD   = 2'd3
  } state_t;

  localparam int DEF_MAX_PIX = 307200;
  localparam int DEF_CNT_W   = $clog2(DEF_MAX_PIX + 1);
  localparam int DEF_SUM_W   = DEF_CNT_W + 8;
  localparam int DEF_INIT_TH = 50;
  localparam int DEF_MIN_TH  = 16;
  localparam int DEF_MAX_TH  = 240;

endpackage

// File: rtl/binarization_threshold_ctrl_if.sv
// rtl/binarization_threshold_ctrl_if.sv - greyscale pixel stream tapped by the threshold controller
interface binarization_threshold_ctrl_if;

  logic       in_href;
  logic       in_vsync;
  logic       in_clken;
  logic [7:0] grey;

  modport master (output in_href, in_vsync, in_clken, grey);
  modport slave  (input  in_href, in_vsync, in_clken, grey);

endinterface

// File: rtl/binarization_threshold_ctrl_serial_divider.sv
// rtl/binarization_threshold_ctrl_serial_divider.sv - restoring divider, one quotient bit per cycle
// done marks the final iteration; quotient is complete from the following cycle.
module serial_divider #(
  parameter int SUM_W = 27,
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             done
);

  localparam int STEP_W = $clog2(SUM_W + 1);

  logic [STEP_W-1:0] step;
  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  dvsr;
  logic [SUM_W-1:0]  quo;
  logic [CNT_W:0]    rem_sh;
  logic              fits;

  // Dividend bits shift out of quo into the remainder while quotient bits shift in.
  assign rem_sh = {rem, quo[SUM_W-1]};
  assign fits   = (rem_sh >= {1'b0, dvsr});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step <= '0;
      rem  <= '0;
      dvsr <= '0;
      quo  <= '0;
    end else if (start) begin
      step <= STEP_W'(SUM_W);
      rem  <= '0;
      dvsr <= divisor;
      quo  <= dividend;
    end else if (step != '0) begin
      rem  <= fits ? (rem_sh[CNT_W-1:0] - dvsr) : rem_sh[CNT_W-1:0];
      quo  <= {quo[SUM_W-2:0], fits};
      step <= step - STEP_W'(1);
    end
  end

  assign quotient = quo;
  assign done     = (step == STEP_W'(1));

endmodule

// File: rtl/binarization_threshold_ctrl.sv
// rtl/binarization_threshold_ctrl.sv - per-frame mean measurement and threshold update at frame boundary
// Define THRESH_SMOOTH_EN to blend each new threshold with the previous measured threshold.
module binarization_threshold_ctrl
  import binarization_pkg::*;
#(
  parameter int MAX_PIX = DEF_MAX_PIX,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int SUM_W   = DEF_SUM_W,
  parameter int INIT_TH = DEF_INIT_TH,
  parameter int OFFSET  = 0,
  parameter int MIN_TH  = DEF_MIN_TH,
  parameter int MAX_TH  = DEF_MAX_TH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  binarization_threshold_ctrl_if.slave  pix,
  input  logic                          manual_en,
  input  logic [7:0]                    manual_th,
  output logic [7:0]                    threshold,
  output logic [7:0]                    mean,
  output logic                          th_valid,
  output logic                          busy,
  output logic                          frame_drop
);

  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_PIX);
  localparam logic signed [9:0] OFF_S   = 10'(OFFSET);
  localparam logic signed [9:0] MIN_S   = 10'(MIN_TH);
  localparam logic signed [9:0] MAX_S   = 10'(MAX_TH);

  state_t            state, state_nx;
  logic              vsync_d;
  logic              vs_rise;
  logic              pix_ok;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  cnt;
  logic              div_start;
  logic              div_done;
  logic [SUM_W-1:0]  quotient;
  logic [7:0]        q8;
  logic signed [9:0] t_raw;
  logic signed [9:0] t_clamped;
  logic [7:0]        t_new;

  assign vs_rise = pix.in_vsync & ~vsync_d;
  assign pix_ok  = pix.in_href & pix.in_clken & ~pix.in_vsync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_d <= 1'b0;
      state   <= IDLE;
    end else begin
      vsync_d <= pix.in_vsync;
      state   <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    case (state)
      IDLE:  if (vs_rise) state_nx = ACCUM;
      ACCUM: if (vs_rise && (cnt != '0)) begin
               div_start = 1'b1;
               state_nx  = DIV;
             end
      DIV:   if (div_done) state_nx = UPD;
      UPD:   state_nx = ACCUM;
      default: state_nx = IDLE;
    endcase
  end

  // Every frame start clears the statistics; a frame ending during DIV/UPD is thereby dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum <= '0;
      cnt <= '0;
    end else if (vs_rise) begin
      sum <= '0;
      cnt <= '0;
    end else if ((state != IDLE) && pix_ok && (cnt < MAX_CNT)) begin
      sum <= sum + {{(SUM_W-8){1'b0}}, pix.grey};
      cnt <= cnt + CNT_W'(1);
    end
  end

  serial_divider #(
    .SUM_W (SUM_W),
    .CNT_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (sum),
    .divisor  (cnt),
    .quotient (quotient),
    .done     (div_done)
  );

  // sum <= 255*cnt bounds the quotient to 8 bits; saturating is purely defensive.
  assign q8    = (|quotient[SUM_W-1:8]) ? 8'hFF : quotient[7:0];
  assign t_raw = $signed({2'b00, q8}) + OFF_S;

  always_comb begin
    t_clamped = t_raw;
    if (t_raw < MIN_S)
      t_clamped = MIN_S;
    else if (t_raw > MAX_S)
      t_clamped = MAX_S;
  end

`ifdef THRESH_SMOOTH_EN
  logic [7:0] th_meas_prev;
  logic [9:0] smooth_sum;

  assign smooth_sum = {2'b00, th_meas_prev} + {1'b0, th_meas_prev, 1'b0}
                    + {2'b00, t_clamped[7:0]} + 10'd2;
  assign t_new      = 8'(smooth_sum >> 2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      th_meas_prev <= 8'(INIT_TH);
    else if (state == UPD)
      th_meas_prev <= t_new;
  end
`else
  assign t_new = t_clamped[7:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      threshold  <= 8'(INIT_TH);
      mean       <= '0;
      th_valid   <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      if (manual_en)
        threshold <= manual_th;
      else if (state == UPD)
        threshold <= t_new;
      if (state == UPD)
        mean <= q8;
      th_valid   <= (state == UPD);
      frame_drop <= vs_rise && ((state == DIV) || (state == UPD));
    end
  end

  assign busy = (state == DIV);

endmodule

// File: tb/tb_binarization_threshold_ctrl.sv
// tb/tb_binarization_threshold_ctrl.sv - scoreboard bench for binarization_threshold_ctrl (OFFSET 0 and -20)
module tb_binarization_threshold_ctrl;

  localparam int SUM_W = 13;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       manual_en;
  logic [7:0] manual_th;
  logic [7:0] thr_a, mean_a, thr_b, mean_b;
  logic       thv_a, busy_a, drop_a, thv_b, busy_b, drop_b;

  always #5 clk = ~clk;

  binarization_threshold_ctrl_if pix();

  binarization_threshold_ctrl #(
    .MAX_PIX(16), .CNT_W(5), .SUM_W(SUM_W), .INIT_TH(50), .OFFSET(0), .MIN_TH(16), .MAX_TH(240)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .pix(pix), .manual_en(manual_en), .manual_th(manual_th),
    .threshold(thr_a), .mean(mean_a), .th_valid(thv_a), .busy(busy_a), .frame_drop(drop_a)
  );

  binarization_threshold_ctrl #(
    .MAX_PIX(16), .CNT_W(5), .SUM_W(SUM_W), .INIT_TH(50), .OFFSET(-20), .MIN_TH(16), .MAX_TH(240)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .pix(pix), .manual_en(manual_en), .manual_th(manual_th),
    .threshold(thr_b), .mean(mean_b), .th_valid(thv_b), .busy(busy_b), .frame_drop(drop_b)
  );

  typedef struct {
    int due;
    int m;
    int a;
    int b;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_vs = 0;
  int   drops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_vs(input bit res, input int m, input int a, input int b);
    exp_t e;
    tick();
    pix.in_vsync = 1'b1;
    pix.in_href  = 1'b0;
    pix.in_clken = 1'b0;
    last_vs = cyc;
    if (res) begin
      e.due = cyc + SUM_W + 2;
      e.m = m;
      e.a = a;
      e.b = b;
      sb.push_back(e);
    end
    tick();
    tick();
    pix.in_vsync = 1'b0;
  endtask

  task automatic pixels(input int n, input int g);
    for (int i = 0; i < n; i++) begin
      tick();
      pix.in_href  = 1'b1;
      pix.in_clken = 1'b1;
      pix.grey     = 8'(g);
    end
    tick();
    pix.in_href  = 1'b0;
    pix.in_clken = 1'b0;
  endtask

  task automatic pad();
    while (cyc - last_vs < SUM_W + 4) tick();
  endtask

  // Monitor: every th_valid pulse is matched against the oldest expected update.
  always @(negedge clk) begin
    exp_t e;
    if (drop_a) drops++;
    if (thv_a) begin
      if (sb.size() == 0) begin
        chk("unexpected_th_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("th_valid_cycle", cyc, e.due);
        chk("mean", mean_a, e.m);
        chk("threshold_off0", thr_a, e.a);
        chk("threshold_offm20", thr_b, e.b);
        chk("th_valid_offm20", thv_b, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pix.in_href  = 1'b0;
    pix.in_vsync = 1'b0;
    pix.in_clken = 1'b0;
    pix.grey     = 8'd0;
    manual_en    = 1'b0;
    manual_th    = 8'd0;
    repeat (3) tick();
    chk("rst_threshold_a", thr_a, 50);
    chk("rst_threshold_b", thr_b, 50);
    chk("rst_mean", mean_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_th_valid", thv_a, 0);
    chk("rst_frame_drop", drop_a, 0);
    reset_n = 1'b1;

    // Pixels before the first frame start are ignored.
    pixels(16, 100);
    pulse_vs(0, 0, 0, 0);

    pixels(16, 100);
    pad();
    pulse_vs(1, 100, 100, 80);
    chk("busy_start", busy_a, 1);
    while (cyc < last_vs + SUM_W) tick();
    chk("busy_last", busy_a, 1);
    tick();
    chk("busy_upd", busy_a, 0);

    pixels(16, 250);
    pad();
    pulse_vs(1, 250, 240, 230);
    pixels(16, 20);
    pad();
    pulse_vs(1, 20, 20, 16);
    pixels(1, 10);
    pixels(2, 11);
    pad();
    pulse_vs(1, 10, 16, 16);
    pixels(20, 200);
    pad();
    pulse_vs(1, 200, 200, 180);

    // Second frame start 5 cycles later falls in DIV.
    pixels(16, 100);
    pad();
    pulse_vs(1, 100, 100, 80);
    tick();
    tick();
    pulse_vs(0, 0, 0, 0);
    pad();
    chk("frame_drop_count", drops, 1);

    pulse_vs(0, 0, 0, 0);
    tick();
    chk("empty_frame_busy", busy_a, 0);
    pixels(16, 60);
    pad();
    pulse_vs(1, 60, 60, 40);
    pad();

    tick();
    manual_en = 1'b1;
    manual_th = 8'd77;
    tick();
    chk("manual_a", thr_a, 77);
    chk("manual_b", thr_b, 77);
    pixels(16, 120);
    pad();
    pulse_vs(1, 120, 77, 77);
    pixels(16, 30);
    manual_th = 8'd90;
    tick();
    chk("manual_change", thr_a, 90);
    manual_en = 1'b0;
    manual_th = 8'd5;
    tick();
    tick();
    chk("manual_hold", thr_a, 90);
    pad();
    pulse_vs(1, 30, 30, 16);

    pixels(16, 180);
    pad();
    pulse_vs(0, 0, 0, 0);
    tick();
    tick();
    chk("busy_before_reset", busy_a, 1);
    reset_n = 1'b0;
    #1;
    chk("reset_busy", busy_a, 0);
    chk("reset_threshold_a", thr_a, 50);
    chk("reset_threshold_b", thr_b, 50);
    chk("reset_mean", mean_a, 0);
    tick();
    reset_n = 1'b1;

    pixels(16, 5);
    pulse_vs(0, 0, 0, 0);
    pixels(16, 200);
    pad();
    pulse_vs(1, 200, 200, 180);
    pad();
    repeat (3) tick();
    chk("scoreboard_empty", sb.size(), 0);
    chk("frame_drop_final", drops, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/binarization_threshold_ctrl.md
# binarization_threshold_ctrl

Per-frame adaptive threshold controller for the binarization stage. It measures the mean grey level of every valid pixel in a frame and computes the next threshold from that mean with a sequential divider. It applies the new threshold at the frame boundary, so the threshold never changes mid-frame. It sits beside the binarization stage, taps the same greyscale stream, and drives that stage's threshold input.

## Interface

Parameters:
- `MAX_PIX`, 307200: maximum counted pixels per frame (640×480).
- `CNT_W`, 19: pixel-counter width, equal to ceil(log2(MAX_PIX+1)).
- `SUM_W`, 27: accumulator width, equal to CNT_W+8.
- `INIT_TH`, 50: threshold value after reset.
- `OFFSET`, 0: signed 9-bit offset added to the measured mean.
- `MIN_TH`, 16: lower clamp for the computed threshold.
- `MAX_TH`, 240: upper clamp for the computed threshold.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_href` in 1: line-valid of the greyscale stream.
- `in_vsync` in 1: frame sync; a rising edge marks frame start.
- `in_clken` in 1: pixel-valid strobe.
- `grey` in 8: greyscale pixel.
- `manual_en` in 1: when 1, `threshold` follows `manual_th`.
- `manual_th` in 8: manual threshold value.
- `threshold` out 8: threshold driven to the binarization stage.
- `mean` out 8: last computed frame mean.
- `th_valid` out 1: one-cycle pulse when `threshold` is updated from measurement.
- `busy` out 1: high while the divider runs.
- `frame_drop` out 1: one-cycle pulse when a frame's statistics are discarded.

## Operation

- Reset values:
  - `threshold` = INIT_TH.
  - `mean`, `th_valid`, `busy` and `frame_drop` = 0.
  - Accumulators are cleared and the FSM is in IDLE.
- Pixel qualification: a pixel is accumulated when `in_href & in_clken & ~in_vsync`.
  - `sum += grey` and `cnt += 1`.
  - Once `cnt` reaches MAX_PIX, both registers hold their value (saturate) for the rest of the frame.
- Frame-start detection: `vs_rise` = `in_vsync & ~vsync_d`, where `vsync_d` is `in_vsync` registered one cycle.
- FSM states:
  - IDLE: on `vs_rise`, clear the accumulators and go to ACCUM. Statistics taken before the first frame start are ignored.
  - ACCUM: accumulate pixels. On `vs_rise`:
    - if `cnt`=0, stay in ACCUM and clear;
    - otherwise, latch the dividend (`sum`) and divisor (`cnt`), clear the accumulators, start the divider and go to DIV.
  - DIV: accumulation of the new frame continues in parallel. The divider takes exactly SUM_W cycles, then the FSM goes to UPD.
  - UPD: one cycle. Compute `t` = quotient[7:0] + OFFSET as a signed 10-bit value, clamp it to [MIN_TH, MAX_TH], register `threshold` (unless `manual_en`) and `mean`, pulse `th_valid`, return to ACCUM.
- Quotient: the true quotient is ≤255 because sum ≤ 255·cnt. The remainder is discarded, so the result truncates toward zero.
- `vs_rise` during DIV or UPD:
  - the division in flight completes normally;
  - the statistics of the frame that just ended are discarded and the accumulators are cleared;
  - `frame_drop` pulses for one cycle.
- Manual mode: when `manual_en`=1, `threshold` = `manual_th`, registered with 1-cycle latency.
  - `mean` and `th_valid` still update.
  - When `manual_en` falls, `threshold` holds `manual_th` until the next UPD.
- Reset asserted mid-frame or mid-division: everything returns to its reset value immediately. After release, the FSM waits in IDLE for the next `vs_rise`.

## Timing

- Reference point: `vs_rise` is high in cycle N.
  - `busy`=1 in cycles N+1 … N+SUM_W.
  - UPD occurs in cycle N+SUM_W+1.
  - `threshold`, `mean` and `th_valid` are visible from cycle N+SUM_W+2; `th_valid` lasts 1 cycle.
- The worst-case latency of 29 cycles is far shorter than the vsync pulse, so the threshold is stable before the first valid pixel of the next frame.
- `manual_th` reaches `threshold` 1 cycle after it is sampled.

## Configuration

- `THRESH_SMOOTH_EN` defined: UPD applies `t_new = (3·threshold_meas_prev + t_clamped + 2) >> 2`.
  - `threshold_meas_prev` is the previous measured threshold, initialised to INIT_TH at reset.
  - The result is always inside [MIN_TH, MAX_TH].
- `THRESH_SMOOTH_EN` undefined: `t_new = t_clamped`, and the smoothing register is not synthesised.

## Structure

- Shared package `binarization_pkg`:
  - FSM state enum (IDLE, ACCUM, DIV, UPD);
  - default MAX_PIX, INIT_TH, MIN_TH and MAX_TH constants;
  - a `clog2`-derived width constant.
- Sub-module `serial_divider`:
  - restoring divider, 1 quotient bit per cycle;
  - ports `start`, `dividend[SUM_W]`, `divisor[CNT_W]`, `quotient[SUM_W]`, `done`;
  - same clock and reset as this block.

## Test plan

- Reset to first frame: release reset → `threshold`=50, `busy`=0. Feed a frame without a preceding `vs_rise` → no `th_valid`.
- Constant frame (MAX_PIX=16, OFFSET=0): `vs_rise`, 16 pixels of grey 100, `vs_rise` → `th_valid` at N+SUM_W+2, `mean`=100, `threshold`=100.
- Clamp: 16 pixels of grey 250 → `mean`=250, `threshold`=240. With OFFSET=−20 and 16 pixels of grey 20 → `threshold`=16.
- Truncation and saturation:
  - 3 pixels {10, 11, 11} → `mean`=10.
  - 20 pixels of grey 200 with MAX_PIX=16 → counting stops at 16, `mean`=200.
- Drop and empty frame:
  - second `vs_rise` 5 cycles after the first → `frame_drop` pulses, only one `th_valid` occurs.
  - empty frame → no `th_valid`, FSM stays in ACCUM.
- Manual and reset:
  - `manual_en`=1, `manual_th`=77 → `threshold`=77 next cycle, `mean` still updates.
  - `reset_n` low mid-DIV → `busy`=0, `threshold`=50 immediately.
